// File: rtl/mc_stage_sequencer.sv
// mc_stage_sequencer: steps one instruction at a time through STAGES
// sequential stages, gates the inter-stage bus captures and keeps retired
// instruction / busy cycle counts.
// Optional stall watchdog: define MC_SEQ_WATCHDOG_EN to build it.
module mc_stage_sequencer #(
  parameter int STAGES  = 5,
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run_en,
  input  logic [STAGES-1:0] stage_over,
  input  logic              early_exit,
  output logic [STAGES-1:0] stage_valid,
  output logic [STAGES-1:0] latch_en,
  output logic              inst_retire,
  output logic [3:0]        state,
  output logic [CNT_W-1:0]  inst_count,
  output logic [CNT_W-1:0]  cycle_count,
  output logic              wdog_err
);

  // Encoding: 0 is IDLE, k+1 is stage k; anything above STAGES is illegal.
  localparam logic [3:0]       ST_IDLE   = 4'd0;
  localparam logic [3:0]       ST_FIRST  = 4'd1;
  localparam logic [3:0]       ST_LAST   = 4'(STAGES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [3:0]        state_q;
  logic [3:0]        state_d;
  logic [STAGES-1:0] exit_mask;
  logic              state_legal;
  logic              state_busy;
  logic              active_over;
  logic              complete;
  logic              stalled;
  logic              wdog_trip;

  // A stage may finish the instruction if it is the last one or early_exit asks for it
  always_comb begin
    exit_mask = {STAGES{early_exit}};
    exit_mask[STAGES-1] = 1'b1;
  end

  // Decode the active stage and derive the capture enables and completion
  always_comb begin
    stage_valid = '0;
    for (int k = 0; k < STAGES; k++) begin
      stage_valid[k] = !reset && (state_q == 4'(k + 1));
    end
    latch_en    = stage_valid & stage_over;
    active_over = |latch_en;
    complete    = |(latch_en & exit_mask);
    inst_retire = complete;
    state_legal = (state_q <= ST_LAST);
    state_busy  = state_legal && (state_q != ST_IDLE);
    stalled     = state_busy && !active_over;
  end

  // Next-state selection; run_en matters only in IDLE and on completion
  always_comb begin
    state_d = state_q;
    if (state_q == ST_IDLE) begin
      state_d = run_en ? ST_FIRST : ST_IDLE;
    end else if (!state_legal) begin
      state_d = ST_IDLE;
    end else if (complete) begin
      state_d = run_en ? ST_FIRST : ST_IDLE;
    end else if (active_over) begin
      state_d = state_q + 4'd1;
    end
    if (wdog_trip) begin
      state_d = ST_IDLE;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Retired-instruction and busy-cycle counters, both free-running and wrapping
  always_ff @(posedge clk) begin
    if (reset) begin
      inst_count  <= '0;
      cycle_count <= '0;
    end else begin
      if (complete) begin
        inst_count <= inst_count + CNT_ONE;
      end
      if (state_busy) begin
        cycle_count <= cycle_count + CNT_ONE;
      end
    end
  end

  assign state = state_q;

`ifdef MC_SEQ_WATCHDOG_EN
  localparam logic [15:0] STALL_LIMIT = 16'(TIMEOUT - 1);

  logic [15:0] stall_cnt;
  logic        wdog_err_q;

  // Abort once the current stage has been stalled for TIMEOUT cycles
  always_comb begin
    wdog_trip = stalled && (stall_cnt == STALL_LIMIT);
  end

  // Consecutive stall cycles in one stage; any progress clears it
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stalled && !wdog_trip) begin
      stall_cnt <= stall_cnt + 16'd1;
    end else begin
      stall_cnt <= '0;
    end
  end

  // Sticky abort flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      wdog_err_q <= 1'b0;
    end else if (wdog_trip) begin
      wdog_err_q <= 1'b1;
    end
  end

  assign wdog_err = wdog_err_q;
`else
  // Without the watchdog a stall simply lasts as long as the stage needs
  always_comb begin
    wdog_trip = 1'b0 & stalled;
  end

  assign wdog_err = 1'b0;
`endif

endmodule

// File: tb/tb_mc_stage_sequencer.sv
// tb_mc_stage_sequencer: directed test of mc_stage_sequencer with STAGES=5.
// A second instance with CNT_W=4 shares the stimulus to exercise counter wrap.
// Watchdog checks follow MC_SEQ_WATCHDOG_EN.
module tb_mc_stage_sequencer;

  localparam int STAGES = 5;

  logic              clk;
  logic              reset;
  logic              run_en;
  logic [STAGES-1:0] stage_over;
  logic              early_exit;

  logic [STAGES-1:0] stage_valid;
  logic [STAGES-1:0] latch_en;
  logic              inst_retire;
  logic [3:0]        state;
  logic [31:0]       inst_count;
  logic [31:0]       cycle_count;
  logic              wdog_err;

  logic [STAGES-1:0] w_stage_valid;
  logic [STAGES-1:0] w_latch_en;
  logic              w_inst_retire;
  logic [3:0]        w_state;
  logic [3:0]        w_inst_count;
  logic [3:0]        w_cycle_count;
  logic              w_wdog_err;

  int compare_count = 0;
  int fail_count    = 0;

  mc_stage_sequencer #(.STAGES(STAGES), .CNT_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .run_en(run_en), .stage_over(stage_over),
    .early_exit(early_exit), .stage_valid(stage_valid), .latch_en(latch_en),
    .inst_retire(inst_retire), .state(state), .inst_count(inst_count),
    .cycle_count(cycle_count), .wdog_err(wdog_err)
  );

  mc_stage_sequencer #(.STAGES(STAGES), .CNT_W(4), .TIMEOUT(4)) dut_wrap (
    .clk(clk), .reset(reset), .run_en(run_en), .stage_over(stage_over),
    .early_exit(early_exit), .stage_valid(w_stage_valid), .latch_en(w_latch_en),
    .inst_retire(w_inst_retire), .state(w_state), .inst_count(w_inst_count),
    .cycle_count(w_cycle_count), .wdog_err(w_wdog_err)
  );

  // Free-running clock, 10 time units per period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compare_count++;
    if (obs !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic run, input logic [STAGES-1:0] over,
                               input logic early);
    reset      = rst;
    run_en     = run;
    stage_over = over;
    early_exit = early;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Directed sequence with hand-computed expectations
  initial begin
    reset = 1'b1; run_en = 1'b0; stage_over = '0; early_exit = 1'b0;

    // Reset with busy-looking inputs: outputs must stay quiet
    applyStimulus(1'b1, 1'b1, 5'b11111, 1'b0);
    tick(); tick();
    checkOutput("rst_valid",  32'(stage_valid), 32'd0);
    checkOutput("rst_latch",  32'(latch_en), 32'd0);
    checkOutput("rst_retire", 32'(inst_retire), 32'd0);
    checkOutput("rst_state",  32'(state), 32'd0);
    checkOutput("rst_inst",   inst_count, 32'd0);
    checkOutput("rst_cycle",  cycle_count, 32'd0);
    checkOutput("rst_wdog",   32'(wdog_err), 32'd0);

    // Streaming: retire in cycles 6, 11, 16
    applyStimulus(1'b0, 1'b1, 5'b11111, 1'b0);
    for (int c = 1; c <= 20; c++) begin
      checkOutput($sformatf("stream_state_c%0d", c), 32'(state),
                  (c == 1) ? 32'd0 : 32'(((c - 2) % 5) + 1));
      checkOutput($sformatf("stream_retire_c%0d", c), 32'(inst_retire),
                  32'((c == 6) || (c == 11) || (c == 16)));
      tick();
    end
    checkOutput("stream_inst",       inst_count, 32'd3);
    checkOutput("stream_cycle",      cycle_count, 32'd19);
    checkOutput("stream_wrap_inst",  32'(w_inst_count), 32'd3);
    checkOutput("stream_wrap_cycle", 32'(w_cycle_count), 32'd3);

    // Reset in stage 3 drops everything without a retire
    tick();
    checkOutput("midrst_state1", 32'(state), 32'd1);
    checkOutput("midrst_inst4",  inst_count, 32'd4);
    tick(); tick(); tick();
    checkOutput("midrst_valid3", 32'(stage_valid), 32'b01000);
    applyStimulus(1'b1, 1'b1, 5'b11111, 1'b0);
    checkOutput("midrst_gated_valid",  32'(stage_valid), 32'd0);
    checkOutput("midrst_gated_retire", 32'(inst_retire), 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 5'b00000, 1'b0);
    checkOutput("midrst_state", 32'(state), 32'd0);
    checkOutput("midrst_inst",  inst_count, 32'd0);
    checkOutput("midrst_cycle", cycle_count, 32'd0);
    checkOutput("midrst_retire", 32'(inst_retire), 32'd0);
    checkOutput("midrst_wrap_inst", 32'(w_inst_count), 32'd0);

    // IDLE holds while run_en is low
    tick();
    checkOutput("idle_hold", 32'(state), 32'd0);

    // Early exit at stage 1
    applyStimulus(1'b0, 1'b1, 5'b00000, 1'b0);
    tick();
    checkOutput("ee_state_s0", 32'(state), 32'd1);
    applyStimulus(1'b0, 1'b1, 5'b00001, 1'b0);
    checkOutput("ee_latch_s0",  32'(latch_en), 32'b00001);
    checkOutput("ee_retire_s0", 32'(inst_retire), 32'd0);
    tick();
    checkOutput("ee_valid_s1", 32'(stage_valid), 32'b00010);
    applyStimulus(1'b0, 1'b1, 5'b00000, 1'b1);
    checkOutput("ee_ignored_retire", 32'(inst_retire), 32'd0);
    checkOutput("ee_ignored_latch",  32'(latch_en), 32'd0);
    tick();
    checkOutput("ee_stall_state", 32'(state), 32'd2);
    applyStimulus(1'b0, 1'b1, 5'b11101, 1'b1);
    checkOutput("ee_inactive_latch",  32'(latch_en), 32'd0);
    checkOutput("ee_inactive_retire", 32'(inst_retire), 32'd0);
    tick();
    checkOutput("ee_inactive_state", 32'(state), 32'd2);
    applyStimulus(1'b0, 1'b1, 5'b00010, 1'b1);
    checkOutput("ee_latch",  32'(latch_en), 32'b00010);
    checkOutput("ee_retire", 32'(inst_retire), 32'd1);
    tick();
    checkOutput("ee_back_s0", 32'(state), 32'd1);
    checkOutput("ee_inst",    inst_count, 32'd1);
    checkOutput("ee_cycle",   cycle_count, 32'd4);

    // Halt: run_en dropped mid-instruction, instruction still finishes
    applyStimulus(1'b0, 1'b1, 5'b11111, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 5'b11111, 1'b0);
    tick(); tick(); tick();
    checkOutput("halt_last_state",  32'(state), 32'd5);
    checkOutput("halt_last_retire", 32'(inst_retire), 32'd1);
    tick();
    checkOutput("halt_idle", 32'(state), 32'd0);
    checkOutput("halt_inst", inst_count, 32'd2);
    tick();
    checkOutput("halt_stay",  32'(state), 32'd0);
    checkOutput("halt_cycle", cycle_count, 32'd9);
    applyStimulus(1'b0, 1'b1, 5'b11111, 1'b0);
    tick();
    checkOutput("restart_state", 32'(state), 32'd1);

    // Stall in stage 2
    tick(); tick();
    applyStimulus(1'b0, 1'b1, 5'b11011, 1'b0);
    checkOutput("stall_latch", 32'(latch_en), 32'd0);
`ifdef MC_SEQ_WATCHDOG_EN
    for (int i = 1; i <= 3; i++) begin
      tick();
      checkOutput($sformatf("wd_hold_%0d", i), 32'(state), 32'd3);
    end
    tick();
    checkOutput("wd_idle",  32'(state), 32'd0);
    checkOutput("wd_err",   32'(wdog_err), 32'd1);
    checkOutput("wd_inst",  inst_count, 32'd2);
    checkOutput("wd_cycle", cycle_count, 32'd15);
    tick();
    checkOutput("wd_sticky", 32'(wdog_err), 32'd1);
    applyStimulus(1'b1, 1'b1, 5'b11111, 1'b0);
    tick();
    checkOutput("wd_rst_clear", 32'(wdog_err), 32'd0);
`else
    repeat (10) tick();
    checkOutput("nowd_state", 32'(state), 32'd3);
    checkOutput("nowd_err",   32'(wdog_err), 32'd0);
    checkOutput("nowd_cycle", cycle_count, 32'd21);
    applyStimulus(1'b1, 1'b1, 5'b11111, 1'b0);
    tick();
`endif

    // Counter wrap: 17 retires from reset
    applyStimulus(1'b0, 1'b1, 5'b11111, 1'b0);
    repeat (86) tick();
    checkOutput("wrap_inst",       32'(w_inst_count), 32'd1);
    checkOutput("wrap_cycle",      32'(w_cycle_count), 32'd5);
    checkOutput("wrap_main_inst",  inst_count, 32'd17);
    checkOutput("wrap_main_cycle", cycle_count, 32'd85);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
    $finish;
  end

endmodule

// File: doc/mc_stage_sequencer.md
MC_STAGE_SEQUENCER -- requirements
Module: mc_stage_sequencer

Interface
REQ-001 SHALL have parameter STAGES, default 5, number of sequential stages (legal 2..8).
REQ-002 SHALL have parameter CNT_W, default 32, width of both performance counters.
REQ-003 SHALL have parameter TIMEOUT, default 255, watchdog stall limit in cycles (legal 1..65535).
REQ-004 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port run_en  in  1  high permits starting or continuing instructions.
REQ-007 SHALL have port stage_over  in  STAGES  per-stage done flag; bit k is sampled only while stage k is active.
REQ-008 SHALL have port early_exit  in  1  with the active stage's over bit, completes the instruction at that stage (branch/no-writeback short path).
REQ-009 SHALL have port stage_valid  out  STAGES  one-hot active-stage indicator; all zero in IDLE.
REQ-010 SHALL have port latch_en  out  STAGES  capture enable for the inter-stage bus register after stage k.
REQ-011 SHALL have port inst_retire  out  1  one-cycle pulse on instruction completion.
REQ-012 SHALL have port state  out  4  encoded state: 0 = IDLE, k+1 = stage k.
REQ-013 SHALL have port inst_count  out  CNT_W  retired-instruction count.
REQ-014 SHALL have port cycle_count  out  CNT_W  count of non-IDLE cycles.
REQ-015 SHALL have port wdog_err  out  1  sticky watchdog-abort flag.

Function
REQ-016 SHALL move from IDLE to stage 0 on the next edge when run_en=1, and hold IDLE when run_en=0.
REQ-017 SHALL drive stage_valid[k]=1 combinationally exactly while state=k+1.
REQ-018 SHALL, in stage k with stage_over[k]=0, remain in stage k.
REQ-019 SHALL, in stage k<STAGES-1 with stage_over[k]=1 and early_exit=0, advance to stage k+1 next cycle.
REQ-020 SHALL define complete = stage_valid[k] & stage_over[k] & (k==STAGES-1 | early_exit).
REQ-021 SHALL, on complete, go to stage 0 if run_en=1, else IDLE; run_en is checked only at IDLE and at complete.
REQ-022 SHALL ignore early_exit when the active stage's over bit is 0, and ignore over bits of inactive stages.
REQ-023 SHALL drive latch_en = stage_valid & stage_over, combinationally, including on the completing stage.
REQ-024 SHALL assert inst_retire combinationally equal to complete.
REQ-025 SHALL increment inst_count on each complete, wrapping modulo 2^CNT_W.
REQ-026 SHALL increment cycle_count every cycle state is non-IDLE, wrapping modulo 2^CNT_W.
REQ-027 SHALL retire one instruction per STAGES cycles when every over bit is high on entry, with zero IDLE cycles between instructions while run_en=1.
REQ-028 SHALL, for an illegal state encoding, return to IDLE next cycle without counting.

Reset
REQ-029 SHALL, when reset=1 at an edge, force state=IDLE, inst_count=0, cycle_count=0, wdog_err=0, and clear the stall counter, regardless of any in-flight instruction.
REQ-030 SHALL, while reset is high, hold stage_valid, latch_en and inst_retire at 0.
REQ-031 SHALL leave the bus registers to the stages; this block only gates their capture through latch_en.

Configuration
REQ-032 SHALL compile the watchdog only when macro MC_SEQ_WATCHDOG_EN is defined.
REQ-033 SHALL, with MC_SEQ_WATCHDOG_EN, count consecutive cycles spent in the same stage with its over bit low, clearing on any stage change.
REQ-034 SHALL, with MC_SEQ_WATCHDOG_EN, force IDLE on the edge after a stage stalls for TIMEOUT cycles, set wdog_err, and not increment inst_count.
REQ-035 SHALL, without MC_SEQ_WATCHDOG_EN, tie wdog_err to 0, build no stall counter, and leave stalls unbounded.

Verification
REQ-036 SHALL verify streaming: STAGES=5, run_en=1, all over=1 for 20 cycles after reset release -> retires at cycles 6,11,16; inst_count=3; cycle_count=19.
REQ-037 SHALL verify early exit: over[1] with early_exit=1 -> stage1 to stage0; inst_retire pulse; latch_en=5'b00010; stages 2-4 never valid.
REQ-038 SHALL verify halt: run_en dropped mid-instruction -> that instruction completes, state goes to 0 and stays there; restart on run_en=1.
REQ-039 SHALL verify reset mid-operation: reset asserted in stage 3 -> next cycle state=0, counters=0, no retire.
REQ-040 SHALL verify watchdog: MC_SEQ_WATCHDOG_EN, TIMEOUT=4, stage 2 over held low -> IDLE after 4 stall cycles; wdog_err=1 sticky; inst_count unchanged.
REQ-041 SHALL verify counter wrap: CNT_W=4 with 17 retires -> inst_count=1.
